// File: rtl/nic_pkg.sv
// Shared rf68000 ring definitions: packet layout, packet type codes and
// well-known node IDs used by NICs and ring servers.
package nic_pkg;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  // Node IDs with a fixed meaning on the ring.
  localparam logic [5:0] NODE_NONE    = 6'd0;
  localparam logic [5:0] NODE_GATEWAY = 6'd62;
  localparam logic [5:0] NODE_BCAST   = 6'd63;

  // Packet type codes.
  localparam logic [4:0] PT_NULL  = 5'd0;
  localparam logic [4:0] PT_READ  = 5'd1;
  localparam logic [4:0] PT_WRITE = 5'd2;
  localparam logic [4:0] PT_AREAD = 5'd3;
  localparam logic [4:0] PT_ACK   = 5'd4;
  localparam logic [4:0] PT_AACK  = 5'd5;
  localparam logic [4:0] PT_ERR   = 5'd6;
  localparam logic [4:0] PT_VPA   = 5'd7;

  typedef struct packed {
    logic [5:0]  sid;
    logic [5:0]  did;
    logic [5:0]  age;
    logic        ack;
    logic [4:0]  typ;
    logic        we;
    logic [3:0]  sel;
    logic [2:0]  fc;
    logic [7:0]  asid;
    logic        mmus;
    logic        ios;
    logic        iops;
    logic [31:0] adr;
    logic [31:0] dat;
  } packet_t;

  // Gateway bus-master sequencer states.
  typedef enum logic [1:0] {
    GW_IDLE = 2'd0,
    GW_BUS  = 2'd1,
    GW_RESP = 2'd2
  } gw_state_t;

  // True for packet types that a ring server executes as a bus cycle.
  function automatic logic is_request(input logic [4:0] typ);
    return (typ == PT_READ) || (typ == PT_AREAD) || (typ == PT_WRITE);
  endfunction

endpackage

// File: rtl/rf68000_pkt_fifo.sv
// Small synchronous packet FIFO with registered full/empty flags.
// A push while full is ignored even if a pop frees a slot in the same cycle.
module rf68000_pkt_fifo #(
  parameter int  DEPTH    = 4,
  parameter type packet_t = logic [7:0]
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    push,
  input  logic    pop,
  input  packet_t din,
  output packet_t dout,
  output logic    full,
  output logic    empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  packet_t         mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            do_push;
  logic            do_pop;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage array: written only on an accepted push.
  always_ff @(posedge clk) begin
    if (do_push && !rst) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers, occupancy count and registered full/empty flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) begin
        wr_ptr <= next_ptr(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      case ({do_push, do_pop})
        2'b10: begin
          count <= count + CW'(1);
          full  <= (count == CW'(DEPTH - 1));
          empty <= 1'b0;
        end
        2'b01: begin
          count <= count - CW'(1);
          full  <= 1'b0;
          empty <= (count == CW'(1));
        end
        default: begin
          count <= count;
        end
      endcase
    end
  end

endmodule

// File: rtl/rf68000_ring_gateway.sv
// Ring-side server node: captures requests addressed to it, runs them as
// bus-master cycles, and inserts the matching response on the response ring.
// Also ages passing request-ring traffic and scrubs over-aged packets.
module rf68000_ring_gateway
  import nic_pkg::*;
#(
  parameter logic [5:0] ID         = NODE_GATEWAY,
  parameter int         DEPTH      = 4,
  parameter logic       SYNC_WRITE = 1'b1,
  parameter int         TIMEOUT    = 256,
  parameter logic [5:0] MAX_AGE    = 6'd63
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  packet_t     packet_i,
  output packet_t     packet_o,
  input  packet_t     rpacket_i,
  output packet_t     rpacket_o,
  output logic        m_cyc_o,
  output logic        m_stb_o,
  output logic        m_we_o,
  output logic [3:0]  m_sel_o,
  output logic [2:0]  m_fc_o,
  output logic [7:0]  m_asid_o,
  output logic        m_mmus_o,
  output logic        m_ios_o,
  output logic        m_iops_o,
  output logic [31:0] m_adr_o,
  output logic [31:0] m_dat_o,
  input  logic        m_ack_i,
  input  logic        m_err_i,
  input  logic        m_vpa_i,
  input  logic [31:0] m_dat_i,
  output logic        busy_o
);

  localparam int TW = $clog2(TIMEOUT + 1);

  gw_state_t     state;
  gw_state_t     state_next;
  packet_t       cur;
  packet_t       resp_tx;
  packet_t       resp_build;
  packet_t       fifo_dout;
  logic          fifo_full;
  logic          fifo_empty;
  logic          push;
  logic          pop;
  logic          build;
  logic          term;
  logic          tmo_hit;
  logic          insert;
  logic [TW-1:0] tmo_count;

  // A request is captured only if the registered full flag allows it.
  assign push    = (packet_i.did == ID) && is_request(packet_i.typ) && !fifo_full;
  assign tmo_hit = (tmo_count == TW'(TIMEOUT - 1));
  assign term    = m_cyc_o && (m_ack_i || m_err_i || m_vpa_i || tmo_hit);
  assign insert  = (rpacket_i.did == NODE_NONE) && (resp_tx.did != NODE_NONE);
  assign busy_o  = !fifo_empty || (state != GW_IDLE);

  rf68000_pkt_fifo #(
    .DEPTH    (DEPTH),
    .packet_t (packet_t)
  ) u_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (push),
    .pop   (pop),
    .din   (packet_i),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Request ring: one-cycle pass-through with capture, discard and aging.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      packet_o <= '0;
    end else begin
      packet_o <= packet_i;
      if (packet_i.did == ID) begin
        // Requests refused because of a full FIFO go round again unaged.
        if (!is_request(packet_i.typ) || !fifo_full) begin
          packet_o.did <= NODE_NONE;
        end
      end else if (packet_i.did != NODE_NONE) begin
        // An age at or beyond the limit is scrubbed so it cannot wrap to 0.
        if (packet_i.age >= (MAX_AGE - 6'd1)) begin
          packet_o.did <= NODE_NONE;
        end else begin
          packet_o.age <= packet_i.age + 6'd1;
        end
      end
    end
  end

  // Sequencer next-state: pop, run the bus cycle, wait for insertion.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    build      = 1'b0;
    case (state)
      GW_IDLE: begin
        if (!fifo_empty && (resp_tx.did == NODE_NONE)) begin
          pop        = 1'b1;
          state_next = GW_BUS;
        end else begin
          state_next = GW_IDLE;
        end
      end
      GW_BUS: begin
        if (term) begin
          if (cur.we && !SYNC_WRITE) begin
            state_next = GW_IDLE;
          end else begin
            build      = 1'b1;
            state_next = GW_RESP;
          end
        end else begin
          state_next = GW_BUS;
        end
      end
      GW_RESP: begin
        // An unroutable response (did 0) is never inserted; do not wait on it.
        if (insert || (resp_tx.did == NODE_NONE)) begin
          state_next = GW_IDLE;
        end else begin
          state_next = GW_RESP;
        end
      end
      default: begin
        state_next = GW_IDLE;
      end
    endcase
  end

  // Response packet built from the current request and the bus termination.
  always_comb begin
    resp_build      = cur;
    resp_build.sid  = ID;
    resp_build.did  = cur.sid;
    resp_build.age  = 6'd0;
    resp_build.ack  = 1'b1;
    resp_build.we   = 1'b0;
    resp_build.sel  = 4'd0;
    resp_build.fc   = 3'd0;
    resp_build.dat  = cur.we ? 32'd0 : m_dat_i;
    if (m_ack_i) begin
      resp_build.typ = (cur.typ == PT_AREAD) ? PT_AACK : PT_ACK;
    end else if (m_err_i) begin
      resp_build.typ = PT_ERR;
    end else if (m_vpa_i) begin
      resp_build.typ = PT_VPA;
    end else begin
      resp_build.typ = PT_ERR;
    end
  end

  // Sequencer state and latched current request.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= GW_IDLE;
      cur   <= '0;
    end else begin
      state <= state_next;
      if (pop) begin
        cur <= fifo_dout;
      end
    end
  end

  // Bus-master outputs: loaded on pop, cleared on any termination.
  always_ff @(posedge clk_i) begin
    if (rst_i || term) begin
      m_cyc_o  <= 1'b0;
      m_stb_o  <= 1'b0;
      m_we_o   <= 1'b0;
      m_sel_o  <= 4'd0;
      m_fc_o   <= 3'd0;
      m_asid_o <= 8'd0;
      m_mmus_o <= 1'b0;
      m_ios_o  <= 1'b0;
      m_iops_o <= 1'b0;
      m_adr_o  <= 32'd0;
      m_dat_o  <= 32'd0;
    end else if (pop) begin
      m_cyc_o  <= 1'b1;
      m_stb_o  <= 1'b1;
      m_we_o   <= fifo_dout.we;
      m_sel_o  <= fifo_dout.sel;
      m_fc_o   <= fifo_dout.fc;
      m_asid_o <= fifo_dout.asid;
      m_mmus_o <= fifo_dout.mmus;
      m_ios_o  <= fifo_dout.ios;
      m_iops_o <= fifo_dout.iops;
      m_adr_o  <= fifo_dout.adr;
      m_dat_o  <= fifo_dout.dat;
    end else begin
      m_cyc_o  <= m_cyc_o;
    end
  end

  // Bus watchdog: counts cycles of an active, unterminated bus cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i || !m_cyc_o || term) begin
      tmo_count <= '0;
    end else begin
      tmo_count <= tmo_count + TW'(1);
    end
  end

  // Pending response: loaded when built, released once on the ring.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      resp_tx <= '0;
    end else if (build) begin
      resp_tx <= resp_build;
    end else if (insert) begin
      resp_tx.did <= NODE_NONE;
    end else begin
      resp_tx <= resp_tx;
    end
  end

  // Response ring: pass-through, pending response fills the first empty slot.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rpacket_o <= '0;
    end else if (insert) begin
      rpacket_o <= resp_tx;
    end else begin
      rpacket_o <= rpacket_i;
    end
  end

endmodule

// File: tb/tb_rf68000_ring_gateway.sv
// Directed self-checking bench for rf68000_ring_gateway.
module tb_rf68000_ring_gateway;
  import nic_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i;
  packet_t     packet_i, packet_o, rpacket_i, rpacket_o;
  logic        m_cyc_o, m_stb_o, m_we_o;
  logic [3:0]  m_sel_o;
  logic [2:0]  m_fc_o;
  logic [7:0]  m_asid_o;
  logic        m_mmus_o, m_ios_o, m_iops_o;
  logic [31:0] m_adr_o, m_dat_o;
  logic        m_ack_i, m_err_i, m_vpa_i;
  logic [31:0] m_dat_i;
  logic        busy_o;

  int checks = 0;
  int errors = 0;

  rf68000_ring_gateway dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .packet_i(packet_i), .packet_o(packet_o),
    .rpacket_i(rpacket_i), .rpacket_o(rpacket_o),
    .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o), .m_we_o(m_we_o),
    .m_sel_o(m_sel_o), .m_fc_o(m_fc_o), .m_asid_o(m_asid_o),
    .m_mmus_o(m_mmus_o), .m_ios_o(m_ios_o), .m_iops_o(m_iops_o),
    .m_adr_o(m_adr_o), .m_dat_o(m_dat_o),
    .m_ack_i(m_ack_i), .m_err_i(m_err_i), .m_vpa_i(m_vpa_i),
    .m_dat_i(m_dat_i), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic packet_t mk(input logic [4:0] typ, input logic [5:0] sid,
                                 input logic [5:0] did, input logic [5:0] age,
                                 input logic [31:0] adr, input logic [31:0] dat);
    packet_t p;
    p     = '0;
    p.typ = typ;
    p.sid = sid;
    p.did = did;
    p.age = age;
    p.adr = adr;
    p.dat = dat;
    p.we  = (typ == PT_WRITE);
    p.sel = 4'hF;
    return p;
  endfunction

  // Wait for a bus cycle, ack it after 'delay' cycles, return the response.
  task automatic serve(input logic [31:0] rdata, input int delay,
                       output packet_t resp, output logic [31:0] adr_seen);
    int n;
    n = 0;
    while (m_cyc_o !== 1'b1 && n < 50) begin tick(); n++; end
    chk("serve_cyc_up", 128'(m_cyc_o), 128'(1'b1));
    adr_seen = m_adr_o;
    repeat (delay) tick();
    m_ack_i = 1'b1; m_dat_i = rdata;
    tick();
    m_ack_i = 1'b0; m_dat_i = 32'd0;
    n = 0;
    while (rpacket_o.did == 6'd0 && n < 50) begin tick(); n++; end
    resp = rpacket_o;
  endtask

  packet_t     p, traffic, resp;
  packet_t     wr [6];
  logic [31:0] adr_seen;
  int          cnt, n;
  logic        seen;

  initial begin
    rst_i = 1'b1; packet_i = '0; rpacket_i = '0;
    m_ack_i = 1'b0; m_err_i = 1'b0; m_vpa_i = 1'b0; m_dat_i = 32'd0;
    tick(); tick();
    chk("rst_packet_o", 128'(packet_o), 128'(0));
    chk("rst_rpacket_o", 128'(rpacket_o), 128'(0));
    chk("rst_cyc", 128'(m_cyc_o), 128'(1'b0));
    chk("rst_busy", 128'(busy_o), 128'(1'b0));
    rst_i = 1'b0;
    tick();

    // ---- Read: sid 3 -> gateway, ack after 3 bus cycles ----
    p = mk(PT_READ, 6'd3, 6'd62, 6'd2, 32'h4000_1000, 32'd0);
    p.fc = 3'd5; p.asid = 8'h12;
    packet_i = p;
    tick();
    packet_i = '0;
    chk("rd_slot_did", 128'(packet_o.did), 128'(6'd0));
    chk("rd_slot_typ", 128'(packet_o.typ), 128'(PT_READ));
    chk("rd_busy", 128'(busy_o), 128'(1'b1));
    chk("rd_cyc_n1", 128'(m_cyc_o), 128'(1'b0));
    tick();
    chk("rd_cyc_n2", 128'(m_cyc_o), 128'(1'b1));
    chk("rd_adr", 128'(m_adr_o), 128'(32'h4000_1000));
    chk("rd_we", 128'(m_we_o), 128'(1'b0));
    chk("rd_fc", 128'(m_fc_o), 128'(3'd5));
    chk("rd_asid", 128'(m_asid_o), 128'(8'h12));
    tick(); tick();
    m_ack_i = 1'b1; m_dat_i = 32'hDEAD_BEEF;
    tick();
    m_ack_i = 1'b0; m_dat_i = 32'd0;
    chk("rd_cyc_drop", 128'(m_cyc_o), 128'(1'b0));
    tick();
    chk("rd_resp_did", 128'(rpacket_o.did), 128'(6'd3));
    chk("rd_resp_sid", 128'(rpacket_o.sid), 128'(6'd62));
    chk("rd_resp_typ", 128'(rpacket_o.typ), 128'(PT_ACK));
    chk("rd_resp_dat", 128'(rpacket_o.dat), 128'(32'hDEAD_BEEF));
    chk("rd_resp_adr", 128'(rpacket_o.adr), 128'(32'h4000_1000));
    chk("rd_resp_age", 128'(rpacket_o.age), 128'(6'd0));
    chk("rd_resp_asid", 128'(rpacket_o.asid), 128'(8'h12));
    chk("rd_idle_busy", 128'(busy_o), 128'(1'b0));
    tick();
    chk("rd_resp_once", 128'(rpacket_o.did), 128'(6'd0));

    // ---- Aging / scrubbing / non-request discard ----
    packet_i = mk(PT_READ, 6'd9, 6'd5, 6'd62, 32'h10, 32'd0);
    tick();
    chk("age62_drop", 128'(packet_o.did), 128'(6'd0));
    packet_i = mk(PT_READ, 6'd9, 6'd5, 6'd10, 32'h10, 32'd0);
    tick();
    chk("age10_did", 128'(packet_o.did), 128'(6'd5));
    chk("age10_age", 128'(packet_o.age), 128'(6'd11));
    packet_i = mk(PT_WRITE, 6'd9, 6'd63, 6'd3, 32'h20, 32'd1);
    tick();
    chk("bcast_did", 128'(packet_o.did), 128'(6'd63));
    chk("bcast_age", 128'(packet_o.age), 128'(6'd4));
    chk("bcast_nocap", 128'(busy_o), 128'(1'b0));
    packet_i = mk(PT_ACK, 6'd9, 6'd62, 6'd3, 32'h30, 32'd2);
    tick();
    chk("nonreq_drop", 128'(packet_o.did), 128'(6'd0));
    chk("nonreq_nocap", 128'(busy_o), 128'(1'b0));
    packet_i = '0;
    tick();

    // ---- Back-pressure: read holds the bus, then 6 writes ----
    packet_i = mk(PT_READ, 6'd20, 6'd62, 6'd0, 32'h2000, 32'd0);
    tick();
    chk("bp_rd_cap", 128'(packet_o.did), 128'(6'd0));
    for (int k = 0; k < 6; k++) begin
      wr[k] = mk(PT_WRITE, 6'(10 + k), 6'd62, 6'd0, 32'h100 * 32'(k + 1), 32'(k + 1));
      packet_i = wr[k];
      tick();
      chk($sformatf("bp_w%0d_did", k), 128'(packet_o.did), 128'((k < 4) ? 6'd0 : 6'd62));
      chk($sformatf("bp_w%0d_age", k), 128'(packet_o.age), 128'(6'd0));
    end
    packet_i = '0;
    serve(32'h1234_5678, 1, resp, adr_seen);
    chk("bp_rd_did", 128'(resp.did), 128'(6'd20));
    chk("bp_rd_dat", 128'(resp.dat), 128'(32'h1234_5678));
    serve(32'hFFFF_FFFF, 0, resp, adr_seen);
    chk("bp_w0_adr", 128'(adr_seen), 128'(32'h100));
    chk("bp_w0_rdid", 128'(resp.did), 128'(6'd10));
    chk("bp_w0_typ", 128'(resp.typ), 128'(PT_ACK));
    chk("bp_w0_dat", 128'(resp.dat), 128'(32'd0));
    // Next lap for the two refused writes.
    packet_i = wr[4];
    tick();
    chk("bp_lap_w4", 128'(packet_o.did), 128'(6'd0));
    packet_i = wr[5];
    tick();
    chk("bp_lap_w5", 128'(packet_o.did), 128'(6'd0));
    packet_i = '0;
    for (int k = 1; k < 6; k++) begin
      serve(32'd0, 0, resp, adr_seen);
      chk($sformatf("bp_w%0d_adr", k), 128'(adr_seen), 128'(32'h100 * 32'(k + 1)));
      chk($sformatf("bp_w%0d_rdid", k), 128'(resp.did), 128'(6'(10 + k)));
      chk($sformatf("bp_w%0d_rtyp", k), 128'(resp.typ), 128'(PT_ACK));
    end
    tick();

    // ---- Timeout on an AREAD ----
    packet_i = mk(PT_AREAD, 6'd4, 6'd62, 6'd0, 32'h80, 32'd0);
    tick();
    packet_i = '0;
    n = 0;
    while (m_cyc_o !== 1'b1 && n < 10) begin tick(); n++; end
    cnt = 0;
    while (m_cyc_o === 1'b1 && cnt < 400) begin tick(); cnt++; end
    chk("tmo_cycles", 128'(cnt), 128'(256));
    tick();
    chk("tmo_resp_did", 128'(rpacket_o.did), 128'(6'd4));
    chk("tmo_resp_typ", 128'(rpacket_o.typ), 128'(PT_ERR));
    tick();

    // ---- Response contention: did 7 traffic for 5 cycles ----
    traffic = mk(PT_ACK, 6'd1, 6'd7, 6'd5, 32'h55, 32'h77);
    packet_i = mk(PT_AREAD, 6'd6, 6'd62, 6'd0, 32'h44, 32'd0);
    tick();
    packet_i = '0;
    n = 0;
    while (m_cyc_o !== 1'b1 && n < 10) begin tick(); n++; end
    rpacket_i = traffic;
    m_ack_i = 1'b1; m_dat_i = 32'hCAFE_F00D;
    tick();
    m_ack_i = 1'b0; m_dat_i = 32'd0;
    chk("cont_pass0", 128'(rpacket_o), 128'(traffic));
    for (int i = 1; i < 5; i++) begin
      tick();
      chk($sformatf("cont_pass%0d", i), 128'(rpacket_o), 128'(traffic));
    end
    rpacket_i = '0;
    tick();
    chk("cont_ins_did", 128'(rpacket_o.did), 128'(6'd6));
    chk("cont_ins_typ", 128'(rpacket_o.typ), 128'(PT_AACK));
    chk("cont_ins_dat", 128'(rpacket_o.dat), 128'(32'hCAFE_F00D));
    tick();
    chk("cont_ins_once", 128'(rpacket_o.did), 128'(6'd0));

    // ---- Reset while a bus cycle is active and FIFO holds 2 ----
    packet_i = mk(PT_READ, 6'd8, 6'd62, 6'd0, 32'h900, 32'd0);
    tick();
    packet_i = mk(PT_READ, 6'd9, 6'd62, 6'd0, 32'h904, 32'd0);
    tick();
    packet_i = mk(PT_READ, 6'd11, 6'd62, 6'd0, 32'h908, 32'd0);
    tick();
    packet_i = '0;
    chk("mid_cyc", 128'(m_cyc_o), 128'(1'b1));
    chk("mid_busy", 128'(busy_o), 128'(1'b1));
    rst_i = 1'b1;
    tick();
    chk("mr_cyc", 128'(m_cyc_o), 128'(1'b0));
    chk("mr_stb", 128'(m_stb_o), 128'(1'b0));
    chk("mr_adr", 128'(m_adr_o), 128'(32'd0));
    chk("mr_busy", 128'(busy_o), 128'(1'b0));
    chk("mr_packet_o", 128'(packet_o), 128'(0));
    chk("mr_rpacket_o", 128'(rpacket_o), 128'(0));
    rst_i = 1'b0;
    seen = 1'b0;
    repeat (20) begin
      tick();
      if (rpacket_o.did != 6'd0 || m_cyc_o || busy_o) seen = 1'b1;
    end
    chk("mr_no_resp", 128'(seen), 128'(1'b0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rf68000_ring_gateway.md
# rf68000_ring_gateway

Ring-side server node for the rf68000 packet ring. It sits downstream of every NIC and is addressed by global node ID 62. It removes request packets addressed to it and queues them in a small FIFO. It runs each queued request as a bus-master cycle on the global memory/I/O bus, then inserts the matching response packet on the response ring. It also scrubs over-aged packets so orphaned traffic cannot circulate forever.

## Interface
- ID, 6'd62, node ID this gateway answers to.
- DEPTH, 4, request FIFO entries (power of two, 2..16).
- SYNC_WRITE, 1'b1, 1 = writes generate PT_ACK/PT_ERR responses; 0 = writes are posted with no response.
- TIMEOUT, 256, bus cycles without ack/err/vpa before the cycle is aborted as an error.
- MAX_AGE, 6'd63, passing packets reaching this age are dropped.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset. One clock domain; reset is synchronous and active-high.
- packet_i / packet_o  in/out  packet_t  request ring in/out.
- rpacket_i / rpacket_o  in/out  packet_t  response ring in/out.
- m_cyc_o, m_stb_o, m_we_o  out  1  bus-master controls.
- m_sel_o  out  4  byte selects.
- m_fc_o  out  3  function code.
- m_asid_o  out  8  address space ID.
- m_mmus_o, m_ios_o, m_iops_o  out  1  space selects.
- m_adr_o, m_dat_o  out  32  address and write data.
- m_ack_i, m_err_i, m_vpa_i  in  1  bus terminations.
- m_dat_i  in  32  read data.
- busy_o  out  1  FIFO non-empty or bus cycle active.

## Operation
- Request ring, registered pass-through each cycle: packet_o <= packet_i, with the following exceptions.
- Capture: if packet_i.did==ID, packet_i.typ is PT_READ, PT_AREAD or PT_WRITE, and the FIFO is not full:
  - push the packet;
  - set packet_o.did <= 0.
- FIFO full: the packet passes unchanged and is retried on the next lap. It is not aged at this node.
- Other typ addressed to ID: discarded (did <= 0).
- Aging: a passing packet with did != 0 and did != ID gets age+1. If age==MAX_AGE-1 on entry, the packet is dropped (did <= 0) instead.
- Broadcasts (did 63) are aged but never captured.
- Bus FSM states IDLE, BUS, RESP:
  - IDLE -> BUS when the FIFO is non-empty and rpacket_tx.did==0. Pop one entry, latch it as cur, drive m_cyc_o = m_stb_o = 1, m_we_o = cur.we, and the other m_* outputs from cur fields.
  - BUS, on termination, priority ack > err > vpa > timeout: clear all bus outputs. Build rpacket_tx with:
    - sid = ID;
    - did = cur.sid;
    - age = 0;
    - ack = 1;
    - adr = cur.adr;
    - dat = m_dat_i (0 for writes);
    - asid, mmus, ios, iops copied from cur;
    - typ = PT_AACK (ack on PT_AREAD), PT_ACK (ack otherwise), PT_ERR (err or timeout), PT_VPA (vpa).
    - For writes with SYNC_WRITE=0, no response is built and the FSM returns to IDLE.
  - BUS -> RESP when a response is built.
  - RESP -> IDLE once rpacket_tx has been inserted.
- Response ring: rpacket_o <= rpacket_i. If rpacket_i.did==0 and rpacket_tx.did!=0, then rpacket_o <= rpacket_tx and rpacket_tx.did <= 0. Response packets are never aged here.
- Timeout counter: cleared on any termination and whenever m_cyc_o==0. It increments while m_cyc_o==1. Reaching TIMEOUT counts as err.

## Timing
- Ring latency is 1 clock for both rings.
- Capture in cycle N: FIFO valid in N+1, IDLE pops in N+1, m_cyc_o high from N+2.
- Termination in cycle T: m_cyc_o low in T+1. Response is eligible for insertion from T+1, at the first empty rpacket_i slot.
- One bus cycle outstanding at a time. The next pop happens no earlier than the cycle after the previous response is inserted.
- Simultaneous push and pop is allowed when full: the pop frees the slot, but the push is refused that cycle because fullness is the registered state.
- Reset, including mid-cycle:
  - all outputs 0; packet_o and rpacket_o all-zero;
  - FIFO empty, FSM IDLE, counter 0, busy_o 0.
  - In-flight requests are lost. Requesters rely on their own recovery.

## Structure
- Shared package nic_pkg supplies packet_t, the PT_* type codes, and TRUE/FALSE. New constant to add there: NODE_GATEWAY = 6'd62.
- Sub-module rf68000_pkt_fifo:
  - parameters DEPTH and type packet_t;
  - synchronous, registered full/empty;
  - pointer wrap-around at DEPTH.
- Remaining logic lives in the top level: ring capture/aging, bus FSM, timeout counter, response insertion.

## Test plan
- Read: PT_READ from sid 3 to did 62, adr 0x40001000; bus acks with 0xDEADBEEF after 3 cycles. Expect PT_ACK with did 3, sid 62, dat 0xDEADBEEF, and request slot did cleared the cycle after capture.
- Back-pressure: inject 6 PT_WRITEs with DEPTH=4 and m_ack_i held low. Expect 4 captured and 2 passing with did 62 intact. After acks they are captured next lap: 6 PT_ACKs in order.
- Timeout: PT_AREAD with no termination. Expect m_cyc_o dropped after 256 cycles and a PT_ERR response, not PT_AACK.
- Aging: packet with did 5 and age 62 passes. Expect did 0 out. With age 10, expect age 11 out.
- Response contention: response ready while rpacket_i carries did 7 for 5 cycles. Expect insertion on the first empty slot, with ring traffic unmodified.
- Reset asserted while m_cyc_o=1 and FIFO holds 2. Expect all outputs 0 the next cycle, busy_o 0, and no response emitted.
